// File: rtl/ysyx_22040386_dmem_pkg.sv
// ysyx_22040386_dmem_pkg: shared widths, FSM states and the request record of the data-memory responder
package ysyx_22040386_dmem_pkg;
    localparam int DM_DATA_W = 64;
    localparam int DM_MASK_W = 8;
    localparam int DM_ADDR_W = 64;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_e;

    typedef struct packed {
        logic                 we;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
        logic [DM_MASK_W-1:0] wmask;
    } dm_req_t;
endpackage

// File: rtl/ysyx_22040386_dmem_resp_if.sv
// ysyx_22040386_dmem_resp_if: MEM-stage load/store request and response channels
interface ysyx_22040386_dmem_resp_if;
    import ysyx_22040386_dmem_pkg::*;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [DM_ADDR_W-1:0] req_addr;
    logic [DM_DATA_W-1:0] req_wdata;
    logic [DM_MASK_W-1:0] req_wmask;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DM_DATA_W-1:0] resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_22040386_dmem_array.sv
// ysyx_22040386_dmem_array: single-port synchronous RAM with per-byte write enables and registered read
module ysyx_22040386_dmem_array
    import ysyx_22040386_dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DM_DATA_W-1:0]  wdata,
    input  logic [DM_MASK_W-1:0]  wmask,
    output logic [DM_DATA_W-1:0]  rdata
);
    logic [DM_DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (!we) rdata <= mem[addr];
            for (int b = 0; b < DM_MASK_W; b++)
                if (we && wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
endmodule

// File: rtl/ysyx_22040386_dmem_resp.sv
// ysyx_22040386_dmem_resp: one-at-a-time data-memory responder with fixed access latency and range check
module ysyx_22040386_dmem_resp
    import ysyx_22040386_dmem_pkg::*;
#(
    parameter int                   DEPTH_LOG2 = 12,
    parameter logic [DM_ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000,
    parameter int                   LATENCY    = 2
) (
    input logic                       i_DM_clk,
    input logic                       i_DM_rst_n,
    ysyx_22040386_dmem_resp_if.slave  dm
);
    localparam logic [3:0] CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;

    dm_state_e            state, state_nxt;
    dm_req_t              req_q, cur;
    logic [3:0]           cnt;
    logic [DM_ADDR_W-1:0] off;
    logic                 in_range, accept, commit, rd_ok, err;
    logic [DM_DATA_W-1:0] q;

    // With LATENCY==1 the commit edge is the accept edge, so the live request is used directly
    always_comb begin
        cur = req_q;
        if (state == DM_IDLE) cur = '{dm.req_we, dm.req_addr, dm.req_wdata, dm.req_wmask};
        off       = cur.addr - BASE_ADDR;
        in_range  = cur.addr >= BASE_ADDR && (off >> (DEPTH_LOG2 + 3)) == '0;
        accept    = state == DM_IDLE && dm.req_valid;
        commit    = i_DM_rst_n && (state == DM_IDLE ? accept && LATENCY == 1
                                                    : state == DM_WAIT && cnt == 4'd0);
        state_nxt = state == DM_IDLE ? (accept ? (LATENCY == 1 ? DM_RESP : DM_WAIT) : DM_IDLE)
                  : state == DM_WAIT ? (cnt == 4'd0 ? DM_RESP : DM_WAIT)
                  : (dm.resp_ready ? DM_IDLE : DM_RESP);
    end

    always_ff @(posedge i_DM_clk or negedge i_DM_rst_n) begin
        if (!i_DM_rst_n) state <= DM_IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge i_DM_clk or negedge i_DM_rst_n) begin
        if (!i_DM_rst_n) begin
            req_q <= '0;
            cnt   <= '0;
            rd_ok <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= cur;
                cnt   <= CNT_INIT;
            end else if (state == DM_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rd_ok <= !cur.we && in_range;
                err   <= !in_range;
            end else if (state == DM_RESP && dm.resp_ready) begin
                rd_ok <= 1'b0;
                err   <= 1'b0;
            end
        end
    end

    ysyx_22040386_dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (i_DM_clk),
        .en    (commit && in_range),
        .we    (cur.we),
        .addr  (off[DEPTH_LOG2+2:3]),
        .wdata (cur.wdata),
        .wmask (cur.wmask),
        .rdata (q)
    );

    assign dm.req_ready  = state == DM_IDLE;
    assign dm.resp_valid = state == DM_RESP;
    assign dm.resp_rdata = rd_ok ? q : '0;
    assign dm.resp_err   = err;
endmodule

// File: tb/tb_ysyx_22040386_dmem_resp.sv
// tb_ysyx_22040386_dmem_resp: directed scoreboard bench for the responder at LATENCY 2 and LATENCY 1
module tb_ysyx_22040386_dmem_resp;
    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   tot = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    ysyx_22040386_dmem_resp_if a();
    ysyx_22040386_dmem_resp_if b();

    ysyx_22040386_dmem_resp #(.LATENCY(2)) u_dut (.i_DM_clk(clk), .i_DM_rst_n(rst_n), .dm(a));
    ysyx_22040386_dmem_resp #(.LATENCY(1)) u_dut1 (.i_DM_clk(clk), .i_DM_rst_n(rst_n), .dm(b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 64'(a.req_ready), 64'd1);
        chk({tag, "_resp_valid"}, 64'(a.resp_valid), 64'd0);
        chk({tag, "_rdata"}, a.resp_rdata, 64'd0);
        chk({tag, "_err"}, 64'(a.resp_err), 64'd0);
    endtask

    task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input logic [63:0] er, input logic ee);
        int n;
        n = 0;
        exp_q.push_back('{er, ee});
        a.req_we    = we;
        a.req_addr  = addr;
        a.req_wdata = wdata;
        a.req_wmask = wmask;
        a.req_valid = 1'b1;
        while (!a.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        a.req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int   lat;
        exp_t e;
        lat = 0;
        while (!a.resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        // edges counted from the accept edge inclusive
        chk("latency", 64'(lat + 1), 64'd2);
        e = exp_q.pop_front();
        chk("rdata", a.resp_rdata, e.rdata);
        chk("err", 64'(a.resp_err), 64'(e.err));
    endtask

    task automatic take();
        a.resp_ready = 1'b1;
        @(posedge clk); #1;
        a.resp_ready = 1'b0;
        chk("valid_drop", 64'(a.resp_valid), 64'd0);
        chk("ready_back", 64'(a.req_ready), 64'd1);
    endtask

    task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [63:0] er, input logic ee);
        issue(we, addr, wdata, wmask, er, ee);
        wait_resp();
        take();
    endtask

    logic        bt_we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] bt_ad [4] = '{64'h8000_0040, 64'h8000_0040, 64'h8000_0048, 64'h8000_0048};
    logic [63:0] bt_wd [4] = '{64'h0123_4567_89AB_CDEF, 64'd0, 64'hFEDC_BA98_7654_3210, 64'd0};
    logic [63:0] bt_er [4] = '{64'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 64'hFEDC_BA98_7654_3210};
    int          acc [4];

    initial begin
        exp_t e;
        int   n;
        a.req_valid = 0; a.req_we = 0; a.req_addr = 0; a.req_wdata = 0; a.req_wmask = 0; a.resp_ready = 0;
        b.req_valid = 0; b.req_we = 0; b.req_addr = 0; b.req_wdata = 0; b.req_wmask = 0; b.resp_ready = 0;
        #3 chk_reset("por");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 0);
        txn(0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 0);
        txn(1, 64'h8000_0010, 64'h0000_00AB_0000_0000, 8'b0001_0000, 64'd0, 0);
        txn(0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_33AB_5566_7788, 0);
        txn(1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 0);
        txn(0, 64'h8000_0017, 64'd0, 8'h00, 64'h1122_33AB_5566_7788, 0);

        txn(1, 64'h8000_0000, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, 64'd0, 0);
        txn(1, 64'h8000_7FF8, 64'hB1B1_B1B1_B1B1_B1B1, 8'hFF, 64'd0, 0);
        txn(0, 64'h8000_7FF8, 64'd0, 8'h00, 64'hB1B1_B1B1_B1B1_B1B1, 0);
        txn(0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1);
        txn(0, 64'h8000_8000, 64'd0, 8'h00, 64'd0, 1);
        txn(1, 64'h8000_8000, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF, 64'd0, 1);
        txn(1, 64'h7FFF_FFF8, 64'hDDDD_DDDD_DDDD_DDDD, 8'hFF, 64'd0, 1);
        txn(0, 64'h8000_0000, 64'd0, 8'h00, 64'hA0A0_A0A0_A0A0_A0A0, 0);
        txn(0, 64'h8000_7FF8, 64'd0, 8'h00, 64'hB1B1_B1B1_B1B1_B1B1, 0);

        issue(0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_33AB_5566_7788, 0);
        wait_resp();
        a.req_we = 1; a.req_addr = 64'h8000_0010; a.req_wdata = 64'd0; a.req_wmask = 8'hFF;
        a.req_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(a.resp_valid), 64'd1);
            chk("bp_rdata", a.resp_rdata, 64'h1122_33AB_5566_7788);
            chk("bp_err", 64'(a.resp_err), 64'd0);
            chk("bp_req_ready", 64'(a.req_ready), 64'd0);
        end
        a.req_valid = 1'b0;
        take();
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_no_accept", 64'(a.resp_valid), 64'd0);
        end
        txn(0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_33AB_5566_7788, 0);

        txn(1, 64'h8000_0020, 64'h5555_5555_5555_5555, 8'hFF, 64'd0, 0);
        issue(1, 64'h8000_0020, 64'h9999_9999_9999_9999, 8'hFF, 64'd0, 0);
        void'(exp_q.pop_back());
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_wait");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_wait_idle", 64'(a.resp_valid), 64'd0);
        txn(0, 64'h8000_0020, 64'd0, 8'h00, 64'h5555_5555_5555_5555, 0);

        issue(0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_33AB_5566_7788, 0);
        wait_resp();
        #1 rst_n = 1'b0;
        #1 chk_reset("rst_resp_ld");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 64'h8000_0030, 64'h7777_7777_7777_7777, 8'hFF, 64'd0, 0);
        wait_resp();
        #1 rst_n = 1'b0;
        #1 chk_reset("rst_resp_st");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        txn(0, 64'h8000_0030, 64'd0, 8'h00, 64'h7777_7777_7777_7777, 0);

        b.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            exp_q.push_back('{bt_er[i], 1'b0});
            b.req_we    = bt_we[i];
            b.req_addr  = bt_ad[i];
            b.req_wdata = bt_wd[i];
            b.req_wmask = 8'hFF;
            b.req_valid = 1'b1;
            while (!b.req_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            acc[i] = cyc;
            @(posedge clk); #1;
            chk("l1_valid", 64'(b.resp_valid), 64'd1);
            e = exp_q.pop_front();
            chk("l1_rdata", b.resp_rdata, e.rdata);
            chk("l1_err", 64'(b.resp_err), 64'(e.err));
            if (i > 0) chk("l1_interval", 64'(acc[i] - acc[i-1]), 64'd2);
        end
        b.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("l1_valid_drop", 64'(b.resp_valid), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule
